// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe timing-model mailbox (writer and poller).
// A mailbox slot is PCIE_REC_WORDS consecutive 32-bit words per thread,
// starting at PCIE_BASE_ADDR + 4*tid. Words 0..2 carry the 96-bit payload,
// word 3 carries the A/B toggle bit (bit PCIE_AB_BIT) and the thread id.
package pcie_pkg;

  localparam int NTHREADS         = 64;
  localparam int NTHREADIDMSB     = 5;
  localparam int PCIE_REC_WORDS   = 4;
  localparam int PCIE_AB_BIT      = 31;
  localparam int PCIE_TID_FIELD_W = 9;
  localparam logic [10:0] PCIE_BASE_ADDR = 11'h000;

  typedef struct packed {
    logic [NTHREADIDMSB:0] tid;
    logic [95:0]           data;
  } pcie_wr_rec_type;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_SEND = 1'b1
  } pcie_wr_state_e;

  // Word address of word w of the slot owned by tid; wraps mod 2048.
  function automatic logic [10:0] pcie_slot_addr(input logic [10:0] base,
                                                 input logic [8:0]  tid,
                                                 input logic [1:0]  w);
    return base + {tid, 2'b00} + {9'b0, w};
  endfunction

endpackage

// File: rtl/pcie_wr_fifo.sv
// Synchronous show-ahead FIFO for the mailbox writer.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointers/count only)
//   push       write wr_data (ignored while full)
//   wr_data    entry to store
//   pop        release the head (ignored while empty)
//   rd_data    current head, valid whenever empty=0
//   count      number of stored entries
//   full       registered, equals (count==DEPTH) after each edge
//   empty      count==0
module pcie_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             full_r;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO rejects a push even when a pop frees a slot this cycle.
  assign push_ok = push & ~full_r;
  assign pop_ok  = pop & (cnt != '0);

  always_comb begin
    cnt_nxt = cnt;
    if (push_ok && !pop_ok) begin
      cnt_nxt = cnt + CW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full_r <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt    <= cnt_nxt;
      full_r <= (cnt_nxt == CW'(DEPTH));
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign count   = cnt;
  assign full    = full_r;
  assign empty   = (cnt == '0);

endmodule

// File: rtl/pcie_tm_writer.sv
// Write side of the PCIe timing-model mailbox.
// Retired tokens are buffered and each is written as a 4-word record into the
// slot of its thread. Word 3 is written last and carries a per-thread A/B bit
// that flips on every record, so the host only treats a slot as new once the
// whole record has landed.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cpu2tm_valid     token present this cycle
//   cpu2tm_retired   token retired (non-retired tokens are ignored)
//   cpu2tm_tid       thread id
//   cpu2tm_data      96-bit token payload
//   fifo_full        registered; tokens offered while high are dropped
//   overflow         sticky; a valid retired token was dropped
//   pcie_we          write strobe
//   pcie_waddr       mailbox word address
//   pcie_wdata       write data
//   pcie_wr_busy     sink stall; a word is taken when pcie_we & ~pcie_wr_busy
module pcie_tm_writer #(
  parameter int          NTHREADS     = 64,
  parameter int          NTHREADIDMSB = 5,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [10:0] BASE_ADDR    = pcie_pkg::PCIE_BASE_ADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu2tm_valid,
  input  logic                    cpu2tm_retired,
  input  logic [NTHREADIDMSB:0]   cpu2tm_tid,
  input  logic [95:0]             cpu2tm_data,
  output logic                    fifo_full,
  output logic                    overflow,
  output logic                    pcie_we,
  output logic [10:0]             pcie_waddr,
  output logic [31:0]             pcie_wdata,
  input  logic                    pcie_wr_busy
);

  import pcie_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [NTHREADIDMSB:0] tid;
    logic [95:0]           data;
  } rec_t;

  rec_t                 wr_rec;
  rec_t                 head;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  pcie_wr_state_e       state;
  pcie_wr_state_e       state_nxt;
  logic [1:0]           w;
  logic [1:0]           w_nxt;
  logic                 last_word;
  logic [NTHREADS-1:0]  ab;
  logic                 ab_flip;

  assign push   = cpu2tm_valid & cpu2tm_retired & ~fifo_full;
  assign wr_rec = '{tid: cpu2tm_tid, data: cpu2tm_data};

  pcie_wr_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_rec),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign last_word = (w == 2'(PCIE_REC_WORDS - 1));

  // Record serialiser. Moving to SEND on the push edge itself lets word 0
  // appear the cycle after a token enters an empty FIFO.
  always_comb begin
    state_nxt  = state;
    w_nxt      = w;
    pop        = 1'b0;
    ab_flip    = 1'b0;
    pcie_we    = 1'b0;
    pcie_waddr = '0;
    pcie_wdata = '0;
    case (state)
      WR_IDLE: begin
        if (!fifo_empty || push) begin
          state_nxt = WR_SEND;
          w_nxt     = '0;
        end
      end
      WR_SEND: begin
        pcie_we    = 1'b1;
        pcie_waddr = pcie_slot_addr(BASE_ADDR, PCIE_TID_FIELD_W'(head.tid), w);
        case (w)
          2'd0:    pcie_wdata = head.data[31:0];
          2'd1:    pcie_wdata = head.data[63:32];
          2'd2:    pcie_wdata = head.data[95:64];
          default: begin
            pcie_wdata[PCIE_AB_BIT]            = ~ab[head.tid];
            pcie_wdata[PCIE_TID_FIELD_W-1:0]   = PCIE_TID_FIELD_W'(head.tid);
          end
        endcase
        if (!pcie_wr_busy) begin
          if (last_word) begin
            pop     = 1'b1;
            ab_flip = 1'b1;
            w_nxt   = '0;
            // Stay in SEND when another record is (or is becoming) available.
            if (fifo_count == CW'(1) && !push) state_nxt = WR_IDLE;
          end else begin
            w_nxt = w + 2'd1;
          end
        end
      end
      default: state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WR_IDLE;
      w        <= '0;
      ab       <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      w     <= w_nxt;
      if (ab_flip) ab[head.tid] <= ~ab[head.tid];
      if (cpu2tm_valid && cpu2tm_retired && fifo_full) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/pcie_tm_writer.md
Name: pcie_tm_writer

Overview:
Write-side companion of the PCIe mailbox poller. It captures retired timing-model tokens from the processor model, buffers them, and serialises each one into a 4-word record in the PCIe write mailbox at a per-thread slot. The last word of each record carries a per-thread A/B toggle bit, so the host sees a new record only after the whole record has landed.

Parameters:
NTHREADS, 64, number of hardware threads / mailbox slots (max 512).
NTHREADIDMSB, 5, MSB of the thread-id field (log2(NTHREADS)-1).
FIFO_DEPTH, 8, token buffer entries (power of 2, >=2).
BASE_ADDR, 11'h000, mailbox word address of slot 0.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu2tm_valid  in  1  token present this cycle
cpu2tm_retired  in  1  token retired; non-retired tokens are replayed and never written
cpu2tm_tid  in  NTHREADIDMSB+1  thread id
cpu2tm_data  in  96  token payload
fifo_full  out  1  registered; tokens offered while high are dropped
overflow  out  1  sticky; set when a valid retired token is dropped
pcie_we  out  1  write strobe
pcie_waddr  out  11  mailbox word address
pcie_wdata  out  32  write data
pcie_wr_busy  in  1  sink stall; a word is accepted when pcie_we=1 and pcie_wr_busy=0

Behaviour:
- Reset: all outputs 0. FIFO empty. FSM in IDLE. Word counter 0. AB[NTHREADS-1:0]=0. Reset mid-record abandons the record with no further strobes; AB for that thread is unchanged.
- Push: when cpu2tm_valid & cpu2tm_retired & ~fifo_full, store {tid, data}. A valid, retired token offered while fifo_full is dropped and overflow is set. A push is rejected when fifo_full=1, even if a pop happens in the same cycle.
- fifo_full: registered; equals (count==FIFO_DEPTH) after each edge. Simultaneous push and pop leaves count unchanged.
- FIFO: show-ahead. The head is visible the cycle after it is pushed into an empty FIFO.
- FSM:
  - IDLE: if FIFO is non-empty, go to SEND with word counter w=0.
  - SEND: drives pcie_we=1.
    - pcie_waddr = BASE_ADDR + {tid,2'b00} + w. Arithmetic is 11-bit and wraps mod 2048.
    - w=0,1,2: pcie_wdata = data[31:0], [63:32], [95:64].
    - w=3: pcie_wdata = {~AB[tid], 22'b0, tid zero-extended to 9 bits}.
    - When a word is accepted (busy=0), w increments.
    - When busy=1, addr, data and we hold stable and w holds.
    - When w=3 is accepted: pop the FIFO, toggle AB[tid], set w=0. If the FIFO is still non-empty after the pop, stay in SEND with the next head, so records go back-to-back with no bubble. Otherwise go to IDLE with pcie_we=0 next cycle.
- Latency: a token pushed at edge N into an empty, idle block produces word0 in cycle N+1. With no stalls, the 4 words appear in N+1..N+4. Sustained throughput is 1 record per 4 cycles.
- Ordering: FIFO order is preserved across threads. Two tokens for the same tid produce two records with opposite AB bits.
- Non-retired or invalid tokens: never stored and never set overflow.

Decomposition:
- pcie_pkg holds:
  - NTHREADS and NTHREADIDMSB
  - PCIE_REC_WORDS=4
  - pcie_wr_rec_type struct {tid, data[95:0]}
  - the AB bit position (31)
  - the shared BASE_ADDR convention for the read-side poller
- Sub-module pcie_wr_fifo: synchronous, show-ahead, parameterised by width and depth, with push/pop/count/full/empty. The top level holds the FSM, the word counter and the AB vector.

Test Plan:
1. After reset, one token (tid=3, data=96'h0000000C_0000000B_0000000A, retired), busy=0 -> 4 strobes over consecutive cycles:
   - 11'h00C=32'hA
   - 11'h00D=32'hB
   - 11'h00E=32'hC
   - 11'h00F=32'h80000003
2. Second token for tid=3 -> word3 = 32'h00000003 (AB toggled back). Other tids are unaffected.
3. busy held high for 3 cycles during w=1 of a tid=0 record -> addr 11'h001 and its data are held stable. The record completes with exactly 4 accepted writes, and no word is duplicated or skipped.
4. Tokens offered on consecutive cycles with busy=1 throughout -> fifo_full rises after 8 pushes. The 9th token is dropped, overflow=1 and stays 1. Releasing busy drains 8 records back-to-back, 32 strobes with no gaps.
5. Token with valid=1, retired=0 -> no FIFO push, no strobe, overflow stays 0.
6. rst asserted at w=2 of a tid=5 record -> next cycle pcie_we=0, FIFO empty, AB[5]=0. A new tid=5 token then writes word3 = 32'h80000005.
